// File: rtl/gate_test_sequencer.sv
// Run controller for the three-input gate checker: debounced START, fixed-length run, frozen verdict.
// Optional SEQ_BUSY_BLINK_EN: busy/error LEDs blink at the checker step rate instead of steady levels.
module gate_test_sequencer #(
    parameter int unsigned STEP_CYCLES     = 50000001,
    parameter int unsigned ROUNDS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn_i,
    input  logic       abort_btn_i,
    input  logic [2:0] gate_sw_i,
    input  logic [2:0] chk_pass_i,
    input  logic [2:0] chk_fail_i,
    output logic       chk_enable_o,
    output logic [2:0] chk_gate_sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [2:0] res_pass_o,
    output logic [2:0] res_fail_o,
    output logic       all_pass_o
);

    localparam longint unsigned RunTotal = 64'(ROUNDS) * 64'd8 * 64'(STEP_CYCLES);
    localparam logic [CNT_W-1:0] RunLast = CNT_W'(RunTotal - 64'd1);
    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StArm    = 3'd1;
    localparam logic [2:0] StRun    = 3'd2;
    localparam logic [2:0] StSettle = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;
    localparam logic [2:0] StError  = 3'd5;

    generate
        if (CNT_W < 64 && RunTotal >= (64'd1 << CNT_W)) begin : g_run_cnt_overflow
            $error("ROUNDS*8*STEP_CYCLES does not fit in CNT_W bits");
        end
    endgenerate

    logic [1:0] start_sync_q, abort_sync_q;
    logic [2:0] gate_sync1_q, gate_sync2_q;
    logic       start_s, abort_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_q <= 2'b00;
            abort_sync_q <= 2'b00;
            gate_sync1_q <= 3'd0;
            gate_sync2_q <= 3'd0;
        end else begin
            start_sync_q <= {start_sync_q[0], start_btn_i};
            abort_sync_q <= {abort_sync_q[0], abort_btn_i};
            gate_sync1_q <= gate_sw_i;
            gate_sync2_q <= gate_sync1_q;
        end
    end

    assign start_s = start_sync_q[1];
    assign abort_s = abort_sync_q[1];

    // One pulse per press: deb_acc_q blocks re-acceptance until the button is released.
    logic [CNT_W-1:0] deb_cnt_q;
    logic             deb_acc_q;
    logic             start_pulse;

    assign start_pulse = start_s && !deb_acc_q && (deb_cnt_q == DebLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
            deb_acc_q <= 1'b0;
        end else if (!start_s) begin
            deb_cnt_q <= '0;
            deb_acc_q <= 1'b0;
        end else if (start_pulse) begin
            deb_cnt_q <= '0;
            deb_acc_q <= 1'b1;
        end else if (!deb_acc_q) begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             settle_q, settle_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       res_pass_q, res_pass_d;
    logic [2:0]       res_fail_q, res_fail_d;

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        settle_d   = settle_q;
        sel_d      = sel_q;
        res_pass_d = res_pass_q;
        res_fail_d = res_fail_q;
        case (state_q)
            StIdle: begin
                if (start_pulse) state_d = StArm;
            end
            StArm: begin
                sel_d      = gate_sync2_q;
                res_pass_d = 3'd0;
                res_fail_d = 3'd0;
                run_cnt_d  = '0;
                settle_d   = 1'b0;
                state_d    = (gate_sync2_q > 3'd4) ? StError : StRun;
            end
            StRun: begin
                // Abort takes priority over the terminal count.
                if (abort_s) begin
                    run_cnt_d = '0;
                    state_d   = StError;
                end else if (run_cnt_q == RunLast) begin
                    run_cnt_d = '0;
                    settle_d  = 1'b0;
                    state_d   = StSettle;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            StSettle: begin
                if (abort_s) begin
                    settle_d = 1'b0;
                    state_d  = StError;
                end else if (settle_q) begin
                    res_pass_d = chk_pass_i;
                    res_fail_d = chk_fail_i;
                    settle_d   = 1'b0;
                    state_d    = StDone;
                end else begin
                    settle_d = 1'b1;
                end
            end
            StDone, StError: begin
                if (start_pulse) state_d = StArm;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            run_cnt_q  <= '0;
            settle_q   <= 1'b0;
            sel_q      <= 3'd0;
            res_pass_q <= 3'd0;
            res_fail_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            settle_q   <= settle_d;
            sel_q      <= sel_d;
            res_pass_q <= res_pass_d;
            res_fail_q <= res_fail_d;
        end
    end

    assign chk_enable_o   = (state_q == StRun);
    assign chk_gate_sel_o = sel_q;
    assign done_o         = (state_q == StDone);
    assign res_pass_o     = res_pass_q;
    assign res_fail_o     = res_fail_q;
    assign all_pass_o     = &res_pass_q;

`ifdef SEQ_BUSY_BLINK_EN
    localparam logic [CNT_W-1:0] StepLast = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] blink_cnt_q;
    logic             blink_q;

    // Phase restarts high on every state change so RUN and ERROR both begin lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (state_d != state_q) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (blink_cnt_q == StepLast) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign busy_o  = (state_q == StRun) ? blink_q : (state_q == StArm || state_q == StSettle);
    assign error_o = (state_q == StError) && blink_q;
`else
    assign busy_o  = (state_q == StArm) || (state_q == StRun) || (state_q == StSettle);
    assign error_o = (state_q == StError);
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer with a queue of expected run outcomes.
module tb_gate_test_sequencer;

    localparam int unsigned Step   = 4;
    localparam int unsigned Rounds = 3;
    localparam int unsigned Deb    = 3;
    localparam int RunCycles = int'(Rounds * 8 * Step);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_btn, abort_btn;
    logic [2:0] gate_sw, chk_pass, chk_fail;
    logic       chk_enable, busy, done, error, all_pass;
    logic [2:0] chk_gate_sel, res_pass, res_fail;

    gate_test_sequencer #(
        .STEP_CYCLES    (Step),
        .ROUNDS         (Rounds),
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_btn_i   (start_btn),
        .abort_btn_i   (abort_btn),
        .gate_sw_i     (gate_sw),
        .chk_pass_i    (chk_pass),
        .chk_fail_i    (chk_fail),
        .chk_enable_o  (chk_enable),
        .chk_gate_sel_o(chk_gate_sel),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error),
        .res_pass_o    (res_pass),
        .res_fail_o    (res_fail),
        .all_pass_o    (all_pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       done;
        logic       err;
        logic [2:0] rp;
        logic [2:0] rf;
        logic       ap;
        int         en;
    } exp_t;

    exp_t sb[$];
    int applied = 0;
    int errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        applied++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] gate, input logic [2:0] pass,
                                   input logic [2:0] fail, input bit aborted);
        exp_t e;
        e.sel = gate;
        if (gate > 3'd4 || aborted) begin
            e.done = 1'b0; e.err = 1'b1; e.rp = 3'd0; e.rf = 3'd0;
            e.en   = (gate > 3'd4) ? 0 : -1;
        end else begin
            e.done = 1'b1; e.err = 1'b0; e.rp = pass; e.rf = fail;
            e.en   = RunCycles;
        end
        e.ap = e.done && (&e.rp);
        return e;
    endfunction

    // Drives START for 'hold' samples and records what the run looked like, one sample per negedge.
    task automatic run(input int hold, input int abort_at, input int chg_t, input logic [2:0] chg_v,
                       output int en, output int arms, output int gap, output logic done_at_arm,
                       output int abort_lat);
        logic prev_busy;
        int first, last_en, ab_t;
        en = 0; arms = 0; first = -1; last_en = -1; ab_t = -1; done_at_arm = 1'bx;
        prev_busy = busy;
        for (int t = 0; t < hold + 130; t++) begin
            @(negedge clk);
            if (chk_enable) begin en++; last_en = t; end
            if (busy && !prev_busy) begin arms++; done_at_arm = done; end
            prev_busy = busy;
            if (arms > 0 && first < 0 && (done || error)) first = t;
            start_btn = (t < hold);
            if (abort_at >= 0 && ab_t < 0 && en == abort_at) begin abort_btn = 1'b1; ab_t = t; end
            if (t == chg_t) gate_sw = chg_v;
        end
        start_btn = 1'b0;
        abort_btn = 1'b0;
        gap       = first - last_en;
        abort_lat = first - ab_t;
    endtask

    task automatic check_end(input string tag, input int en, input int arms);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_arms"}, arms, 1);
        check({tag, "_done"}, done, e.done);
        check({tag, "_error"}, error, e.err);
        check({tag, "_res_pass"}, res_pass, e.rp);
        check({tag, "_res_fail"}, res_fail, e.rf);
        check({tag, "_all_pass"}, all_pass, e.ap);
        check({tag, "_gate_sel"}, chk_gate_sel, e.sel);
        check({tag, "_busy"}, busy, 1'b0);
        if (e.en >= 0) check({tag, "_en_cycles"}, en, e.en);
    endtask

    initial begin
        int en, arms, gap, lat, seen;
        logic dat;

        rst_n = 1'b0; start_btn = 1'b0; abort_btn = 1'b0;
        gate_sw = 3'd0; chk_pass = 3'd0; chk_fail = 3'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {chk_enable, chk_gate_sel, busy, done, error, res_pass, res_fail, all_pass}, 0);
        rst_n = 1'b1;

        // Reset in the middle of a run.
        gate_sw = 3'd1; start_btn = 1'b1; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (chk_enable) seen = 1;
        end
        check("t1_run_started", seen, 1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0; start_btn = 1'b0;
        #1 check("t1_async_reset_outputs",
                 {chk_enable, chk_gate_sel, busy, done, error, res_pass, res_fail, all_pass}, 0);
        @(negedge clk) rst_n = 1'b1;
        en = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (chk_enable) en++;
        end
        check("t1_no_enable_after_reset", en, 0);

        // Normal NAND run, switches moved mid-run.
        gate_sw = 3'd2; chk_pass = 3'b111; chk_fail = 3'b000;
        sb.push_back(model(3'd2, 3'b111, 3'b000, 1'b0));
        run(10, -1, 30, 3'd4, en, arms, gap, dat, lat);
        check_end("t2", en, arms);
        check("t2_done_delay", gap, 3);

        // Short glitch must not start a run.
        run(2, -1, -1, 3'd0, en, arms, gap, dat, lat);
        check("t3_glitch_arms", arms, 0);
        check("t3_glitch_enable", en, 0);

        // Long hold gives exactly one run.
        gate_sw = 3'd0;
        sb.push_back(model(3'd0, 3'b111, 3'b000, 1'b0));
        run(200, -1, -1, 3'd0, en, arms, gap, dat, lat);
        check_end("t3_long_hold", en, arms);

        // Invalid gate code.
        gate_sw = 3'd6;
        sb.push_back(model(3'd6, 3'b111, 3'b000, 1'b0));
        run(10, -1, -1, 3'd0, en, arms, gap, dat, lat);
        check_end("t4_bad_code", en, arms);

        // Abort at RUN cycle 40.
        gate_sw = 3'd1;
        sb.push_back(model(3'd1, 3'b111, 3'b000, 1'b1));
        run(10, 40, -1, 3'd0, en, arms, gap, dat, lat);
        check_end("t5_abort", en, arms);
        check("t5_abort_latency_ok", (lat >= 1 && lat <= 3), 1'b1);
        check("t5_cut_short", (en < RunCycles), 1'b1);

        // Mixed verdict, then a repeat that must clear done in ARM.
        gate_sw = 3'd3; chk_pass = 3'b101; chk_fail = 3'b010;
        sb.push_back(model(3'd3, 3'b101, 3'b010, 1'b0));
        run(10, -1, -1, 3'd0, en, arms, gap, dat, lat);
        check_end("t6_first", en, arms);
        check("t6_done_delay", gap, 3);
        sb.push_back(model(3'd3, 3'b101, 3'b010, 1'b0));
        run(10, -1, -1, 3'd0, en, arms, gap, dat, lat);
        check("t6_done_cleared_in_arm", dat, 1'b0);
        check_end("t6_second", en, arms);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
